// File: rtl/time_chain.sv
// time_chain: cascade of per-stage modulo counters with registered carry tokens.
// Stage 0 counts on cnt_add. Each wrap hands a token, which carries its direction,
// to the next stage one edge later. A wrap of the top stage pulses carryout one edge later.
module time_chain #(
   parameter int unsigned STAGES = 3,
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned MOD0   = 60,
   parameter int unsigned MOD1   = 60,
   parameter int unsigned MOD2   = 24,
   parameter int unsigned MOD3   = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cnt_add,
   input  logic                    dir,
   input  logic                    cnt_end,
   input  logic                    load,
   input  logic [STAGES*WIDTH-1:0] load_val,
   output logic [STAGES*WIDTH-1:0] cnt,
   output logic                    carryout,
   output logic                    busy
);

   localparam int unsigned CW = STAGES * WIDTH;

   // Modulus of stage k. Only indices below STAGES are ever evaluated.
   function automatic int unsigned mod_of(input int unsigned k);
      case (k)
         0:       return MOD0;
         1:       return MOD1;
         2:       return MOD2;
         default: return MOD3;
      endcase
   endfunction

   // Bit 0 of tok and tdir is never set. Stage 0 is driven by cnt_add and dir instead.
   logic [STAGES-1:0] tok, tdir, tok_n, tdir_n;
   logic [STAGES-1:0] step_v, dir_v, wrap;
   logic [CW-1:0]     cnt_n;
   logic              pend, pend_n, carry_n, busy_n;

   // Next-state logic: per-stage step and wrap, then the clear and load overrides.
   always_comb begin
      cnt_n   = cnt;
      wrap    = '0;
      step_v  = tok | STAGES'(cnt_add);
      dir_v   = tdir | STAGES'(dir);
      carry_n = pend;
      for (int unsigned k = 0; k < STAGES; k++) begin
         if (step_v[k]) begin
            if (!dir_v[k]) begin
               if (cnt[k*WIDTH +: WIDTH] == WIDTH'(mod_of(k) - 1)) begin
                  cnt_n[k*WIDTH +: WIDTH] = '0;
                  wrap[k]                 = 1'b1;
               end else begin
                  cnt_n[k*WIDTH +: WIDTH] = cnt[k*WIDTH +: WIDTH] + WIDTH'(1);
               end
            end else begin
               if (cnt[k*WIDTH +: WIDTH] == '0) begin
                  cnt_n[k*WIDTH +: WIDTH] = WIDTH'(mod_of(k) - 1);
                  wrap[k]                 = 1'b1;
               end else begin
                  cnt_n[k*WIDTH +: WIDTH] = cnt[k*WIDTH +: WIDTH] - WIDTH'(1);
               end
            end
         end
      end
      tok_n  = wrap << 1;
      tdir_n = (wrap & dir_v) << 1;
      pend_n = wrap[STAGES-1];
      if (cnt_end) begin
         cnt_n   = '0;
         tok_n   = '0;
         tdir_n  = '0;
         pend_n  = 1'b0;
         carry_n = 1'b0;
      end else if (load) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (32'(load_val[k*WIDTH +: WIDTH]) >= mod_of(k))
               cnt_n[k*WIDTH +: WIDTH] = '0;
            else
               cnt_n[k*WIDTH +: WIDTH] = load_val[k*WIDTH +: WIDTH];
         end
         tok_n   = '0;
         tdir_n  = '0;
         pend_n  = 1'b0;
         carry_n = 1'b0;
      end
      busy_n = |tok_n;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         tok      <= '0;
         tdir     <= '0;
         pend     <= 1'b0;
         carryout <= 1'b0;
         busy     <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         tok      <= tok_n;
         tdir     <= tdir_n;
         pend     <= pend_n;
         carryout <= carry_n;
         busy     <= busy_n;
      end
   end

endmodule

// File: tb/tb_time_chain.sv
// Directed scoreboard checks on the default chain, plus random sweeps of two other configurations.
module tb_time_chain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cnt_add, dir, cnt_end, load;
   logic [17:0] load_val, cnt;
   logic        carryout, busy;

   logic        add_b, dir_b, co_b, busy_b;
   logic [0:0]  cnt_b, lv_b;
   logic        add_c, dir_c, co_c, busy_c;
   logic [15:0] cnt_c, lv_c;
   logic        zero;

   time_chain dut_a (
      .clk(clk), .rst(rst), .cnt_add(cnt_add), .dir(dir), .cnt_end(cnt_end), .load(load),
      .load_val(load_val), .cnt(cnt), .carryout(carryout), .busy(busy));

   time_chain #(.STAGES(1), .WIDTH(1), .MOD0(2)) dut_b (
      .clk(clk), .rst(rst), .cnt_add(add_b), .dir(dir_b), .cnt_end(zero), .load(zero),
      .load_val(lv_b), .cnt(cnt_b), .carryout(co_b), .busy(busy_b));

   time_chain #(.STAGES(4), .WIDTH(4), .MOD0(10), .MOD1(6), .MOD2(10), .MOD3(6)) dut_c (
      .clk(clk), .rst(rst), .cnt_add(add_c), .dir(dir_c), .cnt_end(zero), .load(zero),
      .load_val(lv_c), .cnt(cnt_c), .carryout(co_c), .busy(busy_c));

   typedef struct {
      logic [17:0] cnt;
      logic        co;
      logic        bsy;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] f3(input int a, input int b, input int c);
      return {6'(c), 6'(b), 6'(a)};
   endfunction

   task automatic push(input logic [17:0] c, input logic co, input logic b);
      exp_t e;
      e.cnt = c;
      e.co  = co;
      e.bsy = b;
      sb.push_back(e);
   endtask

   // Advance one edge and compare the DUT against the oldest scoreboard entry.
   task automatic cyc(input string tag);
      exp_t e;
      tick();
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".cnt"},  32'(cnt),      32'(e.cnt));
         chk({tag, ".co"},   32'(carryout), 32'(e.co));
         chk({tag, ".busy"}, 32'(busy),     32'(e.bsy));
      end
   endtask

   int unsigned tb_tot, tc_tot, wb, wc, cb, cc;

   initial begin
      rst = 1'b1; cnt_add = 1'b0; dir = 1'b0; cnt_end = 1'b0; load = 1'b0; load_val = '0;
      add_b = 1'b0; dir_b = 1'b0; add_c = 1'b0; dir_c = 1'b0;
      zero = 1'b0; lv_b = '0; lv_c = '0;
      tb_tot = 0; tc_tot = 0; wb = 0; wc = 0; cb = 0; cc = 0;

      // Reset, then a single up step.
      tick();
      push(f3(0, 0, 0), 1'b0, 1'b0); cyc("reset");
      rst = 1'b0;
      cnt_add = 1'b1; dir = 1'b0;
      push(f3(1, 0, 0), 1'b0, 1'b0); cyc("step1");
      cnt_add = 1'b0;

      // Full ripple from 59/59/23.
      load = 1'b1; load_val = f3(59, 59, 23);
      push(f3(59, 59, 23), 1'b0, 1'b0); cyc("load_full");
      load = 1'b0; cnt_add = 1'b1;
      push(f3(0, 59, 23), 1'b0, 1'b1); cyc("rip_e0");
      cnt_add = 1'b0;
      push(f3(0, 0, 23), 1'b0, 1'b1); cyc("rip_e1");
      push(f3(0, 0, 0), 1'b0, 1'b0);  cyc("rip_e2");
      push(f3(0, 0, 0), 1'b1, 1'b0);  cyc("rip_e3");
      push(f3(0, 0, 0), 1'b0, 1'b0);  cyc("rip_e4");

      // Borrow from 0/0/5.
      load = 1'b1; load_val = f3(0, 0, 5);
      push(f3(0, 0, 5), 1'b0, 1'b0); cyc("load_dn");
      load = 1'b0; cnt_add = 1'b1; dir = 1'b1;
      push(f3(59, 0, 5), 1'b0, 1'b1); cyc("dn_e0");
      cnt_add = 1'b0;
      push(f3(59, 59, 5), 1'b0, 1'b1); cyc("dn_e1");
      push(f3(59, 59, 4), 1'b0, 1'b0); cyc("dn_e2");
      push(f3(59, 59, 4), 1'b0, 1'b0); cyc("dn_e3");
      push(f3(59, 59, 4), 1'b0, 1'b0); cyc("dn_e4");

      // Direction change while an up token is pending.
      load = 1'b1; load_val = f3(59, 10, 0);
      push(f3(59, 10, 0), 1'b0, 1'b0); cyc("load_dc");
      load = 1'b0; cnt_add = 1'b1; dir = 1'b0;
      push(f3(0, 10, 0), 1'b0, 1'b1); cyc("dc_up");
      dir = 1'b1;
      push(f3(59, 11, 0), 1'b0, 1'b1); cyc("dc_dn");
      cnt_add = 1'b0;
      push(f3(59, 10, 0), 1'b0, 1'b0); cyc("dc_settle");

      // cnt_end beats load and cnt_add, and drops the pending ripple.
      load = 1'b1; load_val = f3(59, 59, 23); dir = 1'b0;
      push(f3(59, 59, 23), 1'b0, 1'b0); cyc("load_clr");
      load = 1'b0; cnt_add = 1'b1;
      push(f3(0, 59, 23), 1'b0, 1'b1); cyc("clr_rip");
      cnt_end = 1'b1; load = 1'b1; load_val = f3(7, 7, 7);
      push(f3(0, 0, 0), 1'b0, 1'b0); cyc("clr_hit");
      cnt_end = 1'b0; load = 1'b0; cnt_add = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push(f3(0, 0, 0), 1'b0, 1'b0); cyc("clr_quiet");
      end

      // Out-of-range load fields become 0. A load also ignores cnt_add.
      load = 1'b1; load_val = f3(63, 7, 30);
      push(f3(0, 7, 0), 1'b0, 1'b0); cyc("load_oor");
      cnt_add = 1'b1; load_val = f3(5, 6, 7);
      push(f3(5, 6, 7), 1'b0, 1'b0); cyc("load_add");
      cnt_add = 1'b0; load = 1'b0;

      // Load mid-ripple discards the token.
      load = 1'b1; load_val = f3(59, 59, 23);
      push(f3(59, 59, 23), 1'b0, 1'b0); cyc("load_mr");
      load = 1'b0; cnt_add = 1'b1;
      push(f3(0, 59, 23), 1'b0, 1'b1); cyc("mr_rip");
      cnt_add = 1'b0; load = 1'b1; load_val = f3(1, 2, 3);
      push(f3(1, 2, 3), 1'b0, 1'b0); cyc("mr_load");
      load = 1'b0;
      push(f3(1, 2, 3), 1'b0, 1'b0); cyc("mr_quiet1");
      push(f3(1, 2, 3), 1'b0, 1'b0); cyc("mr_quiet2");

      // Reset mid-ripple.
      load = 1'b1; load_val = f3(59, 59, 23);
      push(f3(59, 59, 23), 1'b0, 1'b0); cyc("load_rr");
      load = 1'b0; cnt_add = 1'b1;
      push(f3(0, 59, 23), 1'b0, 1'b1); cyc("rr_rip");
      cnt_add = 1'b0; rst = 1'b1;
      push(f3(0, 0, 0), 1'b0, 1'b0); cyc("rr_reset");
      rst = 1'b0;
      push(f3(0, 0, 0), 1'b0, 1'b0); cyc("rr_quiet1");
      push(f3(0, 0, 0), 1'b0, 1'b0); cyc("rr_quiet2");

      // Random sweep of both alternate configurations against a mixed-radix total.
      for (int i = 0; i < 1000; i++) begin
         add_b = 1'($urandom_range(0, 1)); dir_b = 1'($urandom_range(0, 1));
         add_c = 1'($urandom_range(0, 1)); dir_c = 1'($urandom_range(0, 1));
         if (add_b) begin
            if (!dir_b) begin
               if (tb_tot == 1) begin tb_tot = 0; wb++; end else tb_tot++;
            end else begin
               if (tb_tot == 0) begin tb_tot = 1; wb++; end else tb_tot--;
            end
         end
         if (add_c) begin
            if (!dir_c) begin
               if (tc_tot == 3599) begin tc_tot = 0; wc++; end else tc_tot++;
            end else begin
               if (tc_tot == 0) begin tc_tot = 3599; wc++; end else tc_tot--;
            end
         end
         tick();
         if (co_b) cb++;
         if (co_c) cc++;
      end
      add_b = 1'b0; add_c = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (co_b) cb++;
         if (co_c) cc++;
      end
      chk("b.cnt",   32'(cnt_b),  tb_tot);
      chk("b.carry", cb,          wb);
      chk("b.busy",  32'(busy_b), 32'(0));
      chk("c.cnt",   32'(cnt_c),
          32'({4'(tc_tot / 600), 4'((tc_tot / 60) % 10), 4'((tc_tot / 10) % 6), 4'(tc_tot % 10)}));
      chk("c.carry", cc,          wc);
      chk("c.busy",  32'(busy_c), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
